// File: rtl/router_reg.sv
// Router datapath register block: header capture, full-stall hold byte,
// running and received parity, and the parity-error flag.
module router_reg (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       lfd_state,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       rst_int_reg,
  output logic [7:0] dout,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic       err
);

  logic [7:0] r_hdr_byte;
  logic [7:0] r_hold_byte;
  logic [7:0] r_int_parity;
  logic [7:0] r_pkt_parity;
  logic [7:0] r_dout;
  logic       r_parity_done;
  logic       r_low_pkt_valid;
  logic       r_err;
  logic       r_pd_d;

  logic w_addr_bad;
  logic w_hdr_ok;
  logic w_hdr_ign;
  logic w_lfd;
  logic w_ld;
  logic w_laf;
  logic w_ld_go;
  logic w_ld_stall;
  logic w_ld_last;
  logic w_pd_rise;

  // detect_add overrides every other state strobe
  assign w_addr_bad = (data_in[1:0] == 2'b11);
  assign w_hdr_ok   = detect_add & pkt_valid & ~w_addr_bad;
  assign w_hdr_ign  = detect_add & pkt_valid & w_addr_bad;
  assign w_lfd      = lfd_state & ~detect_add;
  assign w_ld       = ld_state & ~detect_add;
  assign w_laf      = laf_state & ~detect_add;
  assign w_ld_go    = w_ld & ~fifo_full;
  assign w_ld_stall = w_ld & fifo_full;
  assign w_ld_last  = w_ld & ~pkt_valid;
  assign w_pd_rise  = r_parity_done & ~r_pd_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hdr_byte <= 8'h00;
    end else if (w_hdr_ok) begin
      r_hdr_byte <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout <= 8'h00;
    end else if (w_lfd) begin
      r_dout <= r_hdr_byte;
    end else if (w_ld_go) begin
      r_dout <= data_in;
    end else if (w_laf) begin
      r_dout <= r_hold_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_byte <= 8'h00;
    end else if (w_ld_stall) begin
      r_hold_byte <= data_in;
    end
  end

  // A stalled byte is folded in on LAF, never on the stalled LD cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_int_parity <= 8'h00;
    end else if (detect_add) begin
      r_int_parity <= 8'h00;
    end else if (w_lfd & pkt_valid) begin
      r_int_parity <= r_int_parity ^ r_hdr_byte;
    end else if (w_ld_go & pkt_valid & ~full_state) begin
      r_int_parity <= r_int_parity ^ data_in;
    end else if (w_laf & ~r_low_pkt_valid) begin
      r_int_parity <= r_int_parity ^ r_hold_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_parity <= 8'h00;
    end else if (w_ld_last) begin
      r_pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      r_low_pkt_valid <= 1'b0;
    end else if (w_ld_last) begin
      r_low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity_done <= 1'b0;
    end else if (detect_add) begin
      r_parity_done <= 1'b0;
    end else if ((w_ld_last & ~fifo_full) |
                 (w_laf & r_low_pkt_valid & ~r_parity_done)) begin
      r_parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pd_d <= 1'b0;
    end else begin
      r_pd_d <= r_parity_done;
    end
  end

  // An ignored header must not disturb a pending error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (detect_add & ~w_hdr_ign) begin
      r_err <= 1'b0;
    end else if (w_pd_rise) begin
      r_err <= (r_int_parity != r_pkt_parity);
    end
  end

  assign dout          = r_dout;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;

endmodule
